// File: rtl/lif_spike_logger_if.sv
// Event stream carrying spike-onset timestamps from the logger to the host pipe-out.
// The master side drives the show-ahead FIFO head; the slave side returns ready.
interface lif_spike_logger_if #(
    parameter int TS_W = 32
);
    logic            ev_valid;
    logic            ev_ready;
    logic [TS_W-1:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/lif_spike_logger.sv
// Spike-onset timestamp logger: edge-detects the neuron output, queues free-running
// timestamps in a show-ahead FIFO and reports spikes per fixed rate window.
module lif_spike_logger #(
    parameter int TS_W  = 32,
    parameter int DEPTH = 16,
    parameter int WIN   = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [15:0]              spike_in,
    input  logic                     ts_clear,
    input  logic                     ovf_clr,
    lif_spike_logger_if.master       ev,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    output logic [15:0]              rate,
    output logic                     rate_valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WIN_W = $clog2(WIN);

    logic                 s_q;
    logic [TS_W-1:0]      ts_cnt;
    logic [TS_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [WIN_W-1:0]     win_cnt;
    logic [15:0]          spk_cnt;

    logic spike_any;
    logic e;
    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;
    logic win_end;

    function automatic logic [15:0] sat_inc(input logic [15:0] a, input logic b);
        logic [16:0] s;
        s = {1'b0, a} + {16'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Onset detection and FIFO handshake decode (all from pre-edge state)
    assign spike_any = |spike_in;
    assign e         = spike_any & ~s_q;
    assign push_req  = e & enable;
    assign pop       = ev.ev_valid & ev.ev_ready;
    assign full      = (ev_count == CNT_W'(DEPTH));
    // A pop frees the slot a same-cycle push needs when full
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign win_end   = enable & (win_cnt == WIN_W'(WIN - 1));

    assign ev.ev_valid = (ev_count != '0);
    assign ev.ev_data  = ev.ev_valid ? mem[rd_ptr] : '0;

    // Registered control state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q        <= 1'b0;
            ts_cnt     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ev_count   <= '0;
            overflow   <= 1'b0;
            win_cnt    <= '0;
            spk_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            s_q <= spike_any;

            if (ts_clear)
                ts_cnt <= '0;
            else if (enable)
                ts_cnt <= ts_cnt + TS_W'(1);

            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            ev_count <= ev_count + CNT_W'(push_ok) - CNT_W'(pop);

            // A drop in the same cycle as a clear keeps the flag set
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            rate_valid <= 1'b0;
            if (win_end) begin
                rate       <= sat_inc(spk_cnt, e);
                rate_valid <= 1'b1;
                win_cnt    <= '0;
                spk_cnt    <= '0;
            end else if (enable) begin
                win_cnt <= win_cnt + WIN_W'(1);
                spk_cnt <= sat_inc(spk_cnt, e);
            end
        end
    end

    // Timestamp storage is pure data; validity is tracked by ev_count alone
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= ts_cnt;
    end
endmodule

// File: tb/tb_lif_spike_logger.sv
// Bench for lif_spike_logger: directed scenarios plus random traffic, scored
// against a queue-based behavioural model of the logger.
module tb_lif_spike_logger;
    localparam int TSW   = 4;
    localparam int DEPTH = 16;
    localparam int WIN   = 1000;
    localparam int MASK  = (1 << TSW) - 1;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic [15:0] spike_in = 16'h0;
    logic        ts_clear = 1'b0;
    logic        ovf_clr  = 1'b0;
    logic [4:0]  ev_count;
    logic        overflow;
    logic [15:0] rate;
    logic        rate_valid;

    lif_spike_logger_if #(.TS_W(TSW)) ev_if ();

    lif_spike_logger #(.TS_W(TSW), .DEPTH(DEPTH), .WIN(WIN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .spike_in   (spike_in),
        .ts_clear   (ts_clear),
        .ovf_clr    (ovf_clr),
        .ev         (ev_if.master),
        .ev_count   (ev_count),
        .overflow   (overflow),
        .rate       (rate),
        .rate_valid (rate_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int q[$];
    int m_ts, m_win, m_spk, m_rate;
    bit m_prev, m_ovf, m_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts = 0; m_win = 0; m_spk = 0; m_rate = 0;
        m_prev = 0; m_ovf = 0; m_rv = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        bit onset, pop, drop;
        int cnt;
        onset = (spike_in != 16'h0) && !m_prev;
        pop   = (q.size() > 0) && (ev_if.ev_ready === 1'b1);
        drop  = 0;
        if (pop) void'(q.pop_front());
        if (enable && onset) begin
            if (q.size() < DEPTH) q.push_back(m_ts);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        m_rv = 0;
        if (enable) begin
            cnt = m_spk + (onset ? 1 : 0);
            if (cnt > 65535) cnt = 65535;
            if (m_win == WIN - 1) begin
                m_rate = cnt; m_rv = 1; m_win = 0; m_spk = 0;
            end else begin
                m_win++; m_spk = cnt;
            end
        end
        if (ts_clear) m_ts = 0;
        else if (enable) m_ts = (m_ts + 1) & MASK;
        m_prev = (spike_in != 16'h0);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ev_valid"},   32'(ev_if.ev_valid), 32'(q.size() > 0));
        chk({tag, ".ev_data"},    32'(ev_if.ev_data),  32'((q.size() > 0) ? q[0] : 0));
        chk({tag, ".ev_count"},   32'(ev_count),       32'(q.size()));
        chk({tag, ".overflow"},   32'(overflow),       32'(m_ovf));
        chk({tag, ".rate"},       32'(rate),           32'(m_rate));
        chk({tag, ".rate_valid"}, 32'(rate_valid),     32'(m_rv));
    endtask

    task automatic step(input bit en, input logic [15:0] sp, input bit rdy,
                        input bit clr, input bit oclr, input string tag);
        enable = en; spike_in = sp; ev_if.ev_ready = rdy; ts_clear = clr; ovf_clr = oclr;
        model_edge();
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

    // Asserts reset between edges, checks the immediate clear, releases away from an edge
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0; enable = 1'b0; spike_in = 16'h0;
        ev_if.ev_ready = 1'b0; ts_clear = 1'b0; ovf_clr = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk); #1;
        check_outputs(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_ts[5];
        ev_if.ev_ready = 1'b0;
        model_reset();

        do_reset("reset");

        // Single spike: high before edges 10..12, logged with pre-edge count 9
        for (int i = 1; i <= 9; i++) step(1, 16'h0, 0, 0, 0, "single_pre");
        step(1, 16'hFFFF, 0, 0, 0, "single_on");
        chk("single.valid_rise", 32'(ev_if.ev_valid), 32'd1);
        chk("single.data", 32'(ev_if.ev_data), 32'd9);
        step(1, 16'hFFFF, 0, 0, 0, "single_hold");
        step(1, 16'hFFFF, 0, 0, 0, "single_hold");
        step(1, 16'h0, 0, 0, 0, "single_off");
        chk("single.count", 32'(ev_count), 32'd1);
        step(1, 16'h0, 1, 0, 0, "single_pop");
        chk("single.empty_data", 32'(ev_if.ev_data), 32'd0);

        // Full FIFO: 17 pulses, the last one dropped
        for (int k = 0; k < 17; k++) begin
            step(1, 16'($urandom_range(65535, 1)), 0, 0, 0, "full_pulse");
            step(1, 16'h0, 0, 0, 0, "full_gap");
        end
        chk("full.count", 32'(ev_count), 32'd16);
        chk("full.overflow", 32'(overflow), 32'd1);
        step(1, 16'h0001, 0, 0, 1, "drop_vs_clr");
        chk("drop_vs_clr.overflow", 32'(overflow), 32'd1);
        step(1, 16'h0, 0, 0, 0, "full_gap2");
        step(1, 16'h8000, 1, 0, 0, "full_pushpop");
        chk("full_pushpop.count", 32'(ev_count), 32'd16);
        step(1, 16'h0, 0, 0, 0, "full_gap3");
        for (int k = 0; k < 18; k++) step(1, 16'h0, 1, 0, 0, "full_drain");
        step(1, 16'h0, 0, 0, 1, "ovf_clr");
        chk("ovf_clr.overflow", 32'(overflow), 32'd0);

        // Rate window from a clean reset: onsets at window cycles 100..400 and 999
        do_reset("reset_rate");
        for (int c = 0; c < WIN; c++) begin
            step(1, (c == 100 || c == 200 || c == 300 || c == 400 || c == 999) ? 16'h0010 : 16'h0,
                 1, 0, 0, "rate_win");
        end
        chk("rate.value", 32'(rate), 32'd5);
        chk("rate.pulse", 32'(rate_valid), 32'd1);
        step(1, 16'h0, 1, 0, 0, "rate_next");
        chk("rate.pulse_end", 32'(rate_valid), 32'd0);

        // Enable gap with pulses, then re-enable with spike held high
        for (int c = 0; c < 49; c++) step(0, (c % 2 == 0) ? 16'h0100 : 16'h0, 1, 0, 0, "gap");
        step(0, 16'hFFFF, 0, 0, 0, "gap_last");
        for (int c = 0; c < 4; c++) step(1, 16'hFFFF, 0, 0, 0, "reenable_high");
        chk("reenable.count", 32'(ev_count), 32'd0);
        step(1, 16'h0, 0, 0, 0, "reenable_low");

        // Timestamp wrap and clear with a 4-bit counter
        do_reset("reset_wrap");
        for (int k = 1; k <= 15; k++) step(1, 16'h0, 0, 0, 0, "wrap_idle");
        step(1, 16'h0002, 0, 0, 0, "wrap_at15");
        chk("wrap.head15", 32'(ev_if.ev_data), 32'd15);
        step(1, 16'h0, 0, 0, 0, "wrap_gap");
        step(1, 16'h0002, 0, 0, 0, "wrap_at1");
        for (int k = 19; k <= 32; k++) step(1, 16'h0, 0, 0, 0, "wrap_idle2");
        step(1, 16'h0004, 0, 0, 0, "wrap_at0");
        step(1, 16'h0, 0, 0, 0, "wrap_gap2");
        step(1, 16'h0, 0, 0, 0, "wrap_gap3");
        step(1, 16'h0004, 0, 1, 0, "clear_onset");
        step(1, 16'h0, 0, 0, 0, "clear_gap");
        step(1, 16'h0004, 0, 0, 0, "clear_next");
        exp_ts = '{15, 1, 0, 3, 1};
        for (int k = 0; k < 5; k++) begin
            chk("wrap.drain_data", 32'(ev_if.ev_data), 32'(exp_ts[k]));
            step(1, 16'h0, 1, 0, 0, "wrap_drain");
        end

        // Random traffic with one asynchronous reset mid-run
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset("reset_mid");
            step($urandom_range(9) != 0,
                 ($urandom_range(2) == 0) ? 16'($urandom_range(65535, 1)) : 16'h0,
                 $urandom_range(1) == 1,
                 $urandom_range(31) == 0,
                 $urandom_range(19) == 0,
                 "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
